// File: rtl/serial_transform_echo.sv
`default_nettype none
// ============================================================================
//  Module      : serial_transform_echo
//  Description : Received bytes are transformed on arrival, buffered in a
//                circular FIFO and replayed to a transmitter with an idle
//                gap after every accepted byte. Error and drop counters saturate.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_transform_echo #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    FIFO_DEPTH = 16,
    parameter int                    MODE       = 1,
    parameter logic [DATA_WIDTH-1:0] OPERAND    = 1,
    parameter int                    GAP_CYCLES = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_valid,
    input  logic [DATA_WIDTH-1:0]         rx_data,
    input  logic                          rx_err,
    output logic                          tx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_ready,
    input  logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_cnt,
    output logic [7:0]                    err_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
    // A GAP_CYCLES of 0 still spends the one mandatory cycle in GAP.
    localparam int c_GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic [7:0]            r_drop_cnt;
    logic [7:0]            r_err_cnt;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [GW-1:0]         r_gap_cnt;

    logic                  w_full;
    logic                  w_rx_good;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_xform;

    // Byte transform selected at elaboration time.
    function automatic logic [DATA_WIDTH-1:0] transform(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] x;
        case (MODE)
            0:       x = d;
            1:       x = d + OPERAND;
            2:       x = d ^ OPERAND;
            default: x = ~d;
        endcase
        return x;
    endfunction

    // Ingress qualification: a full FIFO still accepts if the head leaves this cycle.
    always_comb begin
        w_xform   = transform(rx_data);
        w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
        w_rx_good = rx_valid && !rx_err && !rst;
        w_push    = w_rx_good && (!w_full || w_pop);
        w_drop    = w_rx_good && w_full && !w_pop;
        w_err     = rx_valid && rx_err && !rst;
    end

    // FIFO storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_xform;
        end
    end

    // Circular pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating drop and error counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_err  && (r_err_cnt  != 8'hFF)) r_err_cnt  <= r_err_cnt + 1'b1;
        end
    end

    // Transmit FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Transmit FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: if (w_pop)    w_state_next = c_SEND;
            c_SEND: if (tx_ready) w_state_next = c_GAP;
            c_GAP:  if (r_gap_cnt >= GW'(c_GAP_LAST)) w_state_next = c_IDLE;
            default:              w_state_next = c_IDLE;
        endcase
    end

    // Transmit FSM outputs: all derived from registered state, none from inputs directly to ports.
    always_comb begin
        w_pop    = (r_state == c_IDLE) && (r_count != '0) && !tx_busy;
        tx_valid = (r_state == c_SEND);
    end

    // Gap counter runs only while in GAP.
    always_ff @(posedge clk) begin
        if (rst || (r_state != c_GAP)) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

    // Holding register for the byte on offer; reloaded only on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_data <= '0;
        end else if (w_pop) begin
            r_tx_data <= r_mem[r_rd_ptr];
        end
    end

    assign tx_data    = r_tx_data;
    assign fifo_count = r_count;
    assign drop_cnt   = r_drop_cnt;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_serial_transform_echo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_transform_echo
//  Description : Directed, table-driven bench for serial_transform_echo with
//                default parameters (8-bit, depth 16, add 1, gap 10).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_transform_echo;

    localparam int c_GAP = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_busy;
    logic [4:0] fifo_count;
    logic [7:0] drop_cnt;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int exp_err  = 0;

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    serial_transform_echo dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_err     (rx_err),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .drop_cnt   (drop_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic push(input logic [7:0] d, input logic e);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_err   = e;
        tick();
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    // Wait (bounded) for the next offered byte; tx_ready must already be high.
    task automatic expect_tx(input logic [7:0] exp, input string name);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (tx_valid) begin
                seen = 1;
                chk(name, {24'h0, tx_data}, {24'h0, exp});
            end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s: got no tx_valid expected 0x%0h", name, exp);
        end
    endtask

    initial begin
        vecs[0] = '{data: 8'h41, err: 1'b0, exp: 8'h42};
        vecs[1] = '{data: 8'hFF, err: 1'b0, exp: 8'h00};
        vecs[2] = '{data: 8'h00, err: 1'b0, exp: 8'h01};
        vecs[3] = '{data: 8'h55, err: 1'b1, exp: 8'h00};
        vecs[4] = '{data: 8'h7F, err: 1'b0, exp: 8'h80};
        vecs[5] = '{data: 8'hA5, err: 1'b0, exp: 8'hA6};

        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_err = 1'b0;
        tx_ready = 1'b0; tx_busy = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_tx_valid",   {31'h0, tx_valid}, 32'd0);
        chk("rst_tx_data",    {24'h0, tx_data},  32'd0);
        chk("rst_fifo_count", {27'h0, fifo_count}, 32'd0);
        chk("rst_drop_cnt",   {24'h0, drop_cnt}, 32'd0);
        chk("rst_err_cnt",    {24'h0, err_cnt},  32'd0);
        rst = 1'b0;
        tick();

        // Single-byte echo vectors
        for (int v = 0; v < 6; v++) begin
            push(vecs[v].data, vecs[v].err);
            chk("echo_cycle1_idle", {31'h0, tx_valid}, 32'd0);
            tick();
            if (vecs[v].err) begin
                exp_err++;
                chk("err_no_tx",     {31'h0, tx_valid},   32'd0);
                chk("err_cnt",       {24'h0, err_cnt},    exp_err);
                chk("err_fifo_empty",{27'h0, fifo_count}, 32'd0);
            end else begin
                chk("echo_tx_valid", {31'h0, tx_valid}, 32'd1);
                chk("echo_tx_data",  {24'h0, tx_data},  {24'h0, vecs[v].exp});
                tx_ready = 1'b1;
                tick();
                tx_ready = 1'b0;
                chk("echo_accepted", {31'h0, tx_valid}, 32'd0);
            end
            repeat (c_GAP + 2) tick();
        end

        // Burst ordering: transmitter busy keeps bytes queued
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), 1'b0);
        repeat (20) tick();
        chk("burst_count", {27'h0, fifo_count}, 32'd5);
        chk("burst_no_tx", {31'h0, tx_valid},   32'd0);
        tx_busy = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) expect_tx(8'h11 + 8'(i), "burst_order");
        repeat (c_GAP + 2) tick();
        chk("burst_drained", {27'h0, fifo_count}, 32'd0);
        tx_ready = 1'b0;

        // Overflow: 18 bytes into a 16-deep FIFO
        tx_busy = 1'b1;
        for (int i = 0; i < 18; i++) push(8'h80 + 8'(i), 1'b0);
        tick();
        chk("ovf_count",    {27'h0, fifo_count}, 32'd16);
        chk("ovf_drop_cnt", {24'h0, drop_cnt},   32'd2);
        chk("ovf_err_kept", {24'h0, err_cnt},    exp_err);
        tx_busy = 1'b0; tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) expect_tx(8'h81 + 8'(i), "ovf_order");
        repeat (c_GAP + 2) tick();
        chk("ovf_drained", {27'h0, fifo_count}, 32'd0);
        tx_ready = 1'b0;

        // Pacing: distance between consecutive offers
        begin
            int c1 = -1;
            int c2 = -1;
            tx_busy = 1'b1;
            push(8'h20, 1'b0);
            push(8'h21, 1'b0);
            tx_busy = 1'b0; tx_ready = 1'b1;
            for (int i = 0; i < 60 && c2 < 0; i++) begin
                tick();
                if (tx_valid) begin
                    if (c1 < 0) begin
                        c1 = cyc;
                        chk("pace_first", {24'h0, tx_data}, 32'h21);
                    end else begin
                        c2 = cyc;
                        chk("pace_second", {24'h0, tx_data}, 32'h22);
                    end
                end
            end
            chk("pace_distance", 32'(c2 - c1), c_GAP + 2);
            repeat (c_GAP + 2) tick();
            tx_ready = 1'b0;
        end

        // tx_busy holds the FSM in IDLE
        tx_busy = 1'b1;
        push(8'h33, 1'b0);
        repeat (5) tick();
        chk("busy_hold_no_tx", {31'h0, tx_valid},   32'd0);
        chk("busy_hold_count", {27'h0, fifo_count}, 32'd1);
        tx_busy = 1'b0; tx_ready = 1'b1;
        expect_tx(8'h34, "busy_release");
        repeat (c_GAP + 2) tick();
        tx_ready = 1'b0;

        // Reset while in SEND, with an rx strobe during reset
        push(8'h30, 1'b0);
        push(8'h31, 1'b0);
        tick();
        chk("pre_rst_send", {31'h0, tx_valid}, 32'd1);
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
        tick();
        rst = 1'b0; rx_valid = 1'b0;
        chk("rst_send_tx_valid", {31'h0, tx_valid},   32'd0);
        chk("rst_send_count",    {27'h0, fifo_count}, 32'd0);
        chk("rst_send_drop",     {24'h0, drop_cnt},   32'd0);
        chk("rst_send_err",      {24'h0, err_cnt},    32'd0);
        chk("rst_send_tx_data",  {24'h0, tx_data},    32'd0);
        tx_ready = 1'b1;
        begin
            int stale = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (tx_valid) stale++;
            end
            chk("rst_no_stale_tx", stale, 32'd0);
        end
        chk("rst_rx_ignored", {27'h0, fifo_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
